// File: rtl/ex_unit.sv
// ex_unit: single-issue execute stage. ALU ops complete in one cycle; MUL
// (op 9) runs a 32-step shift-add multiplier and stalls upstream meanwhile.
// Build option: define EX_UNIT_MUL_EN to compile in the multiplier and its
// MUL_BUSY state; otherwise op 9 behaves as a reserved op and stall is 0.
module ex_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [4:0]  RD_EX,
  output logic        stall,
  output logic [31:0] result,
  output logic [4:0]  RD_MEM,
  output logic        valid_out
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
`ifdef EX_UNIT_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd9;
`endif

  // Single-cycle ops; everything unlisted (reserved, and MUL when the
  // multiplier is not built) yields 0.
  function automatic logic [31:0] alu(input logic [3:0] o,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (o)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SLT: r = {31'd0, $signed(a) < $signed(b)};
      OP_SLL: r = a << b[4:0];
      OP_SRL: r = a >> b[4:0];
      OP_SRA: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [31:0] result_nxt;
  logic [4:0]  rd_nxt;
  logic        vo_nxt;

`ifdef EX_UNIT_MUL_EN
  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t      state, state_nxt;
  logic [31:0] mcand, mcand_nxt;
  logic [31:0] mplier, mplier_nxt;
  logic [31:0] acc, acc_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [4:0]  rd_lat, rd_lat_nxt;
  logic [31:0] acc_step;

  // Registered, so stall has no combinational path from the inputs.
  assign stall = (state == MUL_BUSY);

  // Partial-product add for the current multiplier bit.
  assign acc_step = acc + (mplier[0] ? mcand : 32'd0);

  // Next-state and next-output logic; MUL_BUSY ignores all inputs.
  always_comb begin
    state_nxt  = state;
    result_nxt = result;
    rd_nxt     = RD_MEM;
    vo_nxt     = 1'b0;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    rd_lat_nxt = rd_lat;
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (op == OP_MUL) begin
            mcand_nxt  = D1;
            mplier_nxt = D2;
            rd_lat_nxt = RD_EX;
            acc_nxt    = '0;
            cnt_nxt    = '0;
            state_nxt  = MUL_BUSY;
          end else begin
            result_nxt = (RD_EX == 5'd0) ? 32'd0 : alu(op, D1, D2);
            rd_nxt     = RD_EX;
            vo_nxt     = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        acc_nxt    = acc_step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + 5'd1;
        if (cnt == 5'd31) begin
          result_nxt = (rd_lat == 5'd0) ? 32'd0 : acc_step;
          rd_nxt     = rd_lat;
          vo_nxt     = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, multiplier datapath and output registers; reset aborts any MUL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      rd_lat    <= '0;
      result    <= '0;
      RD_MEM    <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      mcand     <= mcand_nxt;
      mplier    <= mplier_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      rd_lat    <= rd_lat_nxt;
      result    <= result_nxt;
      RD_MEM    <= rd_nxt;
      valid_out <= vo_nxt;
    end
  end
`else
  assign stall = 1'b0;

  // Single-cycle issue; outputs hold when no bundle is offered.
  always_comb begin
    result_nxt = result;
    rd_nxt     = RD_MEM;
    vo_nxt     = 1'b0;
    if (valid_in) begin
      result_nxt = (RD_EX == 5'd0) ? 32'd0 : alu(op, D1, D2);
      rd_nxt     = RD_EX;
      vo_nxt     = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result    <= '0;
      RD_MEM    <= '0;
      valid_out <= 1'b0;
    end else begin
      result    <= result_nxt;
      RD_MEM    <= rd_nxt;
      valid_out <= vo_nxt;
    end
  end
`endif

endmodule
